// File: rtl/pb_sched_pkg.sv
// Shared types and constants for the PB job scheduler and the PB checkers.
package pb_sched_pkg;

   typedef enum logic [1:0] {IDLE, START, WAIT_IRQ, DONE} sched_state_e;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_BAD_SEL = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;

   localparam logic [3:0] OP0 = 4'h0;
   localparam logic [3:0] OP1 = 4'h1;
   localparam logic [3:0] OP2 = 4'h2;

endpackage

// File: rtl/pb_job_sched_if.sv
// Requester descriptor/completion bus plus PB config port; the master is the scheduler.
interface pb_job_sched_if #(parameter int NUM_REQ = 2);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ-1:0][31:0] req_addr_in;
   logic [NUM_REQ-1:0][31:0] req_addr_out;
   logic [NUM_REQ-1:0][3:0]  req_byte_cnt;
   logic [NUM_REQ-1:0][3:0]  req_data_sel;
   logic [NUM_REQ-1:0]       req_crc_en;
   logic [NUM_REQ-1:0][7:0]  req_crc_val;

   logic                     pb_start;
   logic [31:0]              pb_addr_in;
   logic [31:0]              pb_addr_out;
   logic [3:0]               pb_byte_cnt;
   logic [3:0]               pb_data_sel;
   logic                     pb_crc_en;
   logic [7:0]               pb_crc_val;
   logic                     pb_irq;

   logic [NUM_REQ-1:0]       done_valid;
   logic [1:0]               done_status;

   modport master (
      input  req_valid, req_addr_in, req_addr_out, req_byte_cnt, req_data_sel,
             req_crc_en, req_crc_val, pb_irq,
      output req_ready, pb_start, pb_addr_in, pb_addr_out, pb_byte_cnt,
             pb_data_sel, pb_crc_en, pb_crc_val, done_valid, done_status
   );

   modport slave (
      output req_valid, req_addr_in, req_addr_out, req_byte_cnt, req_data_sel,
             req_crc_en, req_crc_val, pb_irq,
      input  req_ready, pb_start, pb_addr_in, pb_addr_out, pb_byte_cnt,
             pb_data_sel, pb_crc_en, pb_crc_val, done_valid, done_status
   );

endinterface

// File: rtl/pb_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above rr_ptr, with wrap.
module pb_rr_arbiter #(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] gnt_oh,
   output logic [IDX_W-1:0]   gnt_idx
);

   // One spare bit so rr_ptr + i cannot overflow before the wrap subtract.
   logic [IDX_W:0] k;
   logic           found;

   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      found   = 1'b0;
      k       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         k = {1'b0, rr_ptr} + (IDX_W+1)'(i);
         if (k >= (IDX_W+1)'(NUM_REQ))
            k = k - (IDX_W+1)'(NUM_REQ);
         if (!found && req[k[IDX_W-1:0]]) begin
            found                  = 1'b1;
            gnt_oh[k[IDX_W-1:0]]   = 1'b1;
            gnt_idx                = k[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/pb_job_sched.sv
// PB job scheduler: round-robin descriptor intake, PB config/start, completion return.
// Optional watchdog in WAIT_IRQ enabled by defining PB_SCHED_TIMEOUT_EN.
module pb_job_sched
   import pb_sched_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic            clk,
   input  logic            reset,
   pb_job_sched_if.master  bus,
   output logic            busy
);

   localparam int IDX_W = $clog2(NUM_REQ);

   sched_state_e       state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   grant_id;
   logic [IDX_W-1:0]   gnt_idx;
   logic [NUM_REQ-1:0] gnt_oh;
   logic               accept;
   logic               to_expire;

   pb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req     (bus.req_valid),
      .rr_ptr  (rr_ptr),
      .gnt_oh  (gnt_oh),
      .gnt_idx (gnt_idx)
   );

   assign bus.req_ready = (state == IDLE && !reset) ? gnt_oh : '0;
   assign accept        = |bus.req_ready;
   assign busy          = (state != IDLE);

`ifdef PB_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES);

   logic [TO_W-1:0] to_cnt;

   // Held at zero outside WAIT_IRQ, so it is clear on every entry.
   always_ff @(posedge clk) begin
      if (reset || state != WAIT_IRQ)
         to_cnt <= '0;
      else if (to_cnt != '1)
         to_cnt <= to_cnt + 1'b1;
   end

   assign to_expire = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign to_expire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         rr_ptr          <= '0;
         grant_id        <= '0;
         bus.pb_start    <= 1'b0;
         bus.pb_addr_in  <= '0;
         bus.pb_addr_out <= '0;
         bus.pb_byte_cnt <= '0;
         bus.pb_data_sel <= '0;
         bus.pb_crc_en   <= 1'b0;
         bus.pb_crc_val  <= '0;
         bus.done_valid  <= '0;
         bus.done_status <= ST_OK;
      end else begin
         bus.pb_start   <= 1'b0;
         bus.done_valid <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  grant_id        <= gnt_idx;
                  bus.pb_addr_in  <= bus.req_addr_in[gnt_idx];
                  bus.pb_addr_out <= bus.req_addr_out[gnt_idx];
                  bus.pb_byte_cnt <= bus.req_byte_cnt[gnt_idx];
                  bus.pb_data_sel <= bus.req_data_sel[gnt_idx];
                  bus.pb_crc_en   <= bus.req_crc_en[gnt_idx];
                  bus.pb_crc_val  <= bus.req_crc_val[gnt_idx];
                  // Illegal select completes straight away; PB never sees it.
                  if (bus.req_data_sel[gnt_idx] > OP2) begin
                     bus.done_status <= ST_BAD_SEL;
                     bus.done_valid  <= gnt_oh;
                     state           <= DONE;
                  end else begin
                     bus.pb_start <= 1'b1;
                     state        <= START;
                  end
               end
            end
            START: state <= WAIT_IRQ;
            WAIT_IRQ: begin
               if (bus.pb_irq) begin
                  bus.done_status <= ST_OK;
                  bus.done_valid  <= NUM_REQ'(1) << grant_id;
                  state           <= DONE;
               end else if (to_expire) begin
                  bus.done_status <= ST_TIMEOUT;
                  bus.done_valid  <= NUM_REQ'(1) << grant_id;
                  state           <= DONE;
               end
            end
            DONE: begin
               rr_ptr <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
